pc_next_datapath: RTL and testbench

- Fetch-stage next-PC datapath: holds the program counter and computes PC+4.
- Selects the next PC from four sources: sequential, BTB prediction, resolved branch target, and mispredict recovery.
- Built from two reusable primitives, adder32 and mux2_1, plus one PC register.
- Sits between the branch predictor/BTB and the instruction memory address port.

---
 rtl/pc_next_datapath_pkg.sv | 14 +
 rtl/adder32.sv | 18 +
 rtl/mux2_1.sv | 19 +
 rtl/pc_next_datapath.sv | 77 +++++++
 tb/tb_pc_next_datapath.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_next_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_datapath_pkg
// Description : Shared definitions for the fetch-stage next-PC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_next_datapath_pkg;

    typedef logic [31:0] word_t;

    localparam word_t C_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : pc_next_datapath_pkg
`default_nettype wire

// File: rtl/adder32.sv
`default_nettype none
// ============================================================================
// Module      : adder32
// Description : 32-bit combinational adder, result modulo 2^32 (no carry out).
// Revision    : 1.0 - initial release
// ============================================================================
module adder32
    import pc_next_datapath_pkg::*;
(
    input  word_t A,
    input  word_t B,
    output word_t OUT
);

    assign OUT = A + B;

endmodule : adder32
`default_nettype wire

// File: rtl/mux2_1.sv
`default_nettype none
// ============================================================================
// Module      : mux2_1
// Description : Parameterised 2:1 multiplexer, SEL=0 picks A, SEL=1 picks B.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_1 #(
    parameter int WIDTH = 32
) (
    input  logic             SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] OUT
);

    assign OUT = SEL ? B : A;

endmodule : mux2_1
`default_nettype wire

// File: rtl/pc_next_datapath.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_datapath
// Description : Fetch PC register plus PC+4 adder and next-PC selection chain.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_datapath
    import pc_next_datapath_pkg::*;
#(
    parameter word_t RESET_PC = C_RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_En,
    input  logic        Predict_Taken_F,
    input  logic [31:0] PC_Prediction,
    input  logic        Predict_Taken_E,
    input  logic        Branch_Taken_E,
    input  logic [31:0] PC_Target_E,
    input  logic [31:0] PC_Plus_4_E,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus_4_F
);

    localparam word_t C_PC_STEP = 32'd4;

    word_t r_pc;
    word_t w_pc_plus_4;
    word_t w_pc_predict;
    word_t w_pc_next;
    word_t w_pc_in;
    logic  w_recover;

    adder32 u_pc_adder (
        .A   (r_pc),
        .B   (C_PC_STEP),
        .OUT (w_pc_plus_4)
    );

    // Later stages in the chain override earlier ones, so the execute-stage
    // recovery mux is last and therefore has the highest priority.
    mux2_1 #(.WIDTH(32)) m_pred (
        .SEL (Predict_Taken_F),
        .A   (w_pc_plus_4),
        .B   (PC_Prediction),
        .OUT (w_pc_predict)
    );

    mux2_1 #(.WIDTH(32)) m_branch (
        .SEL (Branch_Taken_E),
        .A   (w_pc_predict),
        .B   (PC_Target_E),
        .OUT (w_pc_next)
    );

    assign w_recover = Predict_Taken_E & ~Branch_Taken_E;

    mux2_1 #(.WIDTH(32)) m_recover (
        .SEL (w_recover),
        .A   (w_pc_next),
        .B   (PC_Plus_4_E),
        .OUT (w_pc_in)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= RESET_PC;
        end else if (PC_En) begin
            r_pc <= w_pc_in;
        end
    end

    assign PC_F        = r_pc;
    assign PC_Plus_4_F = w_pc_plus_4;

endmodule : pc_next_datapath
`default_nettype wire

// File: tb/tb_pc_next_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_next_datapath
// Description : Directed self-checking bench for the next-PC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_datapath;

    logic        clk;
    logic        rst;
    logic        pc_en;
    logic        predict_taken_f;
    logic [31:0] pc_prediction;
    logic        predict_taken_e;
    logic        branch_taken_e;
    logic [31:0] pc_target_e;
    logic [31:0] pc_plus_4_e;
    logic [31:0] pc_f;
    logic [31:0] pc_plus_4_f;

    logic [31:0] add_a, add_b, add_out;
    logic        mux_sel;
    logic [31:0] mux_a, mux_b, mux_out;

    int errors = 0;
    int checks = 0;

    pc_next_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .CLK             (clk),
        .RST             (rst),
        .PC_En           (pc_en),
        .Predict_Taken_F (predict_taken_f),
        .PC_Prediction   (pc_prediction),
        .Predict_Taken_E (predict_taken_e),
        .Branch_Taken_E  (branch_taken_e),
        .PC_Target_E     (pc_target_e),
        .PC_Plus_4_E     (pc_plus_4_e),
        .PC_F            (pc_f),
        .PC_Plus_4_F     (pc_plus_4_f)
    );

    adder32 u_add (.A(add_a), .B(add_b), .OUT(add_out));
    mux2_1 #(.WIDTH(32)) u_mux (.SEL(mux_sel), .A(mux_a), .B(mux_b), .OUT(mux_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_selects();
        predict_taken_f = 1'b0;
        predict_taken_e = 1'b0;
        branch_taken_e  = 1'b0;
        pc_prediction   = 32'h0;
        pc_target_e     = 32'h0;
        pc_plus_4_e     = 32'h0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        pc_en           = 1'b0;
        predict_taken_f = 1'b1;
        pc_prediction   = 32'hAAAA_5554;
        predict_taken_e = 1'b1;
        branch_taken_e  = 1'b0;
        pc_target_e     = 32'h1234_0000;
        pc_plus_4_e     = 32'h5555_0000;
        step();
        step();
        checks++;
        if (pc_f !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", pc_f, 32'h0);
        end
        checks++;
        if (pc_plus_4_f !== 32'h4) begin
            errors++;
            $display("FAIL reset_pc_plus_4: got %h expected %h", pc_plus_4_f, 32'h4);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h4;
        exp_seq[1] = 32'h8;
        exp_seq[2] = 32'hC;
        clear_selects();
        rst   = 1'b0;
        pc_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc_f !== exp_seq[i]) begin
                errors++;
                $display("FAIL seq_step%0d: got %h expected %h", i, pc_f, exp_seq[i]);
            end
        end
        pc_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (pc_f !== 32'hC) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, pc_f, 32'hC);
            end
        end
    endtask

    task automatic test_prediction();
        pc_en = 1'b1;
        step();
        checks++;
        if (pc_f !== 32'h10) begin
            errors++;
            $display("FAIL pred_setup: got %h expected %h", pc_f, 32'h10);
        end
        predict_taken_f = 1'b1;
        pc_prediction   = 32'h80;
        step();
        checks++;
        if (pc_f !== 32'h80) begin
            errors++;
            $display("FAIL pred_taken: got %h expected %h", pc_f, 32'h80);
        end
        checks++;
        if (pc_plus_4_f !== 32'h84) begin
            errors++;
            $display("FAIL pred_plus4: got %h expected %h", pc_plus_4_f, 32'h84);
        end
        branch_taken_e = 1'b1;
        pc_target_e    = 32'h200;
        step();
        checks++;
        if (pc_f !== 32'h200) begin
            errors++;
            $display("FAIL branch_over_pred: got %h expected %h", pc_f, 32'h200);
        end
    endtask

    task automatic test_recovery();
        clear_selects();
        predict_taken_e = 1'b1;
        branch_taken_e  = 1'b0;
        pc_plus_4_e     = 32'h24;
        predict_taken_f = 1'b1;
        pc_prediction   = 32'h80;
        pc_target_e     = 32'h400;
        step();
        checks++;
        if (pc_f !== 32'h24) begin
            errors++;
            $display("FAIL recovery: got %h expected %h", pc_f, 32'h24);
        end
        // Correct taken prediction resolves to the execute target.
        branch_taken_e = 1'b1;
        pc_target_e    = 32'h300;
        step();
        checks++;
        if (pc_f !== 32'h300) begin
            errors++;
            $display("FAIL correct_taken: got %h expected %h", pc_f, 32'h300);
        end
        clear_selects();
        branch_taken_e = 1'b1;
        pc_target_e    = 32'h103;
        step();
        checks++;
        if (pc_f !== 32'h103) begin
            errors++;
            $display("FAIL unaligned_pc: got %h expected %h", pc_f, 32'h103);
        end
        checks++;
        if (pc_plus_4_f !== 32'h107) begin
            errors++;
            $display("FAIL unaligned_plus4: got %h expected %h", pc_plus_4_f, 32'h107);
        end
    endtask

    task automatic test_wrap();
        clear_selects();
        branch_taken_e = 1'b1;
        pc_target_e    = 32'hFFFF_FFFC;
        step();
        checks++;
        if (pc_f !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_load: got %h expected %h", pc_f, 32'hFFFF_FFFC);
        end
        checks++;
        if (pc_plus_4_f !== 32'h0) begin
            errors++;
            $display("FAIL wrap_plus4: got %h expected %h", pc_plus_4_f, 32'h0);
        end
        clear_selects();
        step();
        checks++;
        if (pc_f !== 32'h0) begin
            errors++;
            $display("FAIL wrap_seq: got %h expected %h", pc_f, 32'h0);
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_selects();
        pc_en = 1'b1;
        step();
        step();
        pc_en          = 1'b0;
        rst            = 1'b1;
        branch_taken_e = 1'b1;
        pc_target_e    = 32'h500;
        step();
        checks++;
        if (pc_f !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %h expected %h", pc_f, 32'h0);
        end
        clear_selects();
        rst   = 1'b0;
        pc_en = 1'b1;
        step();
        checks++;
        if (pc_f !== 32'h4) begin
            errors++;
            $display("FAIL first_after_reset: got %h expected %h", pc_f, 32'h4);
        end
    endtask

    task automatic test_primitives();
        add_a = 32'h7FFF_FFFF;
        add_b = 32'h1;
        #1;
        checks++;
        if (add_out !== 32'h8000_0000) begin
            errors++;
            $display("FAIL adder_signed_edge: got %h expected %h", add_out, 32'h8000_0000);
        end
        add_a = 32'hFFFF_FFFF;
        add_b = 32'h2;
        #1;
        checks++;
        if (add_out !== 32'h1) begin
            errors++;
            $display("FAIL adder_wrap: got %h expected %h", add_out, 32'h1);
        end
        mux_a   = 32'hDEAD_BEEF;
        mux_b   = 32'h1234_5678;
        mux_sel = 1'b0;
        #1;
        checks++;
        if (mux_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mux_sel0: got %h expected %h", mux_out, 32'hDEAD_BEEF);
        end
        mux_sel = 1'b1;
        #1;
        checks++;
        if (mux_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mux_sel1: got %h expected %h", mux_out, 32'h1234_5678);
        end
    endtask

    initial begin
        rst     = 1'b1;
        pc_en   = 1'b0;
        add_a   = 32'h0;
        add_b   = 32'h0;
        mux_sel = 1'b0;
        mux_a   = 32'h0;
        mux_b   = 32'h0;
        clear_selects();
        test_reset();
        test_sequential();
        test_prediction();
        test_recovery();
        test_wrap();
        test_reset_mid_stall();
        test_primitives();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_next_datapath
`default_nettype wire
